// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC comb/decimator section.
package cic_pkg;

  localparam int unsigned CIC_IN_W_DEF  = 24;
  localparam int unsigned CIC_OUT_W_DEF = 12;

  localparam int unsigned CIC_N_DEF = 3;
  localparam int unsigned CIC_N_MIN = 1;
  localparam int unsigned CIC_N_MAX = 6;

  localparam int unsigned CIC_R_DEF = 8;
  localparam int unsigned CIC_R_MIN = 2;
  localparam int unsigned CIC_R_MAX = 256;

  localparam int unsigned CIC_M_DEF = 1;
  localparam int unsigned CIC_M_MIN = 1;
  localparam int unsigned CIC_M_MAX = 2;

  // Register growth of an N-stage CIC: N * ceil(log2(R*M)).
  function automatic int unsigned cic_growth(input int unsigned n,
                                             input int unsigned r,
                                             input int unsigned m);
    return n * $clog2(r * m);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb stage: M-deep delay line, modular subtractor and valid flop,
// advancing only on decimated-sample strobes.
module cic_comb_stage #(
  parameter int unsigned W = 24,
  parameter int unsigned M = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o
);

  logic [M-1:0][W-1:0] dly_q, dly_d;
  logic [W-1:0]        out_q, out_d;
  logic                vld_q, vld_d;

  always_comb begin
    dly_d = dly_q;
    out_d = out_q;
    vld_d = 1'b0;
    if (clr_i) begin
      dly_d = '0;
    end else if (in_valid_i) begin
      vld_d    = 1'b1;
      out_d    = in_data_i - dly_q[M-1];
      dly_d[0] = in_data_i;
      for (int k = 1; k < M; k++) dly_d[k] = dly_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      dly_q <= dly_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign out_data_o  = out_q;
  assign out_valid_o = vld_q;

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC back end: decimates the integrator output by R, then runs N_STAGES
// comb stages and truncates the result to OUT_W bits.
module cic_comb_decimator
  import cic_pkg::*;
#(
  parameter int unsigned IN_W     = CIC_IN_W_DEF,
  parameter int unsigned OUT_W    = CIC_OUT_W_DEF,
  parameter int unsigned N_STAGES = CIC_N_DEF,
  parameter int unsigned R        = CIC_R_DEF,
  parameter int unsigned M        = CIC_M_DEF,
  parameter int unsigned SHIFT    = IN_W - OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  x,
  input  logic             x_valid,
  input  logic             phase_clr,
  output logic [OUT_W-1:0] y,
  output logic             y_valid
);

  localparam int unsigned     PH_W    = $clog2(R);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(R - 1);

  if ((IN_W < OUT_W + SHIFT) ||
      (N_STAGES < CIC_N_MIN) || (N_STAGES > CIC_N_MAX) ||
      (R < CIC_R_MIN) || (R > CIC_R_MAX) ||
      (M < CIC_M_MIN) || (M > CIC_M_MAX)) begin : g_param_err
    $error("cic_comb_decimator: illegal parameter combination");
  end

  logic [PH_W-1:0] phase_q, phase_d;
  logic [IN_W-1:0] d0_q, d0_d;
  logic            v0_q, v0_d;

  // Phase counter and decimation register; a clear drops any same-cycle sample.
  always_comb begin
    phase_d = phase_q;
    d0_d    = d0_q;
    v0_d    = 1'b0;
    if (phase_clr) begin
      phase_d = '0;
    end else if (x_valid) begin
      if (phase_q == PH_LAST) begin
        phase_d = '0;
        d0_d    = x;
        v0_d    = 1'b1;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      d0_q    <= '0;
      v0_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      d0_q    <= d0_d;
      v0_q    <= v0_d;
    end
  end

  logic [N_STAGES:0][IN_W-1:0] s_data;
  logic [N_STAGES:0]           s_valid;

  assign s_data[0]  = d0_q;
  assign s_valid[0] = v0_q;

  for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
    cic_comb_stage #(
      .W (IN_W),
      .M (M)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (phase_clr),
      .in_data_i   (s_data[i]),
      .in_valid_i  (s_valid[i]),
      .out_data_o  (s_data[i+1]),
      .out_valid_o (s_valid[i+1])
    );
  end

  // Final stage registers already hold between strobes, so y is a plain slice.
  assign y       = s_data[N_STAGES][SHIFT +: OUT_W];
  assign y_valid = s_valid[N_STAGES];

  logic unused_tail;
  assign unused_tail = ^s_data[N_STAGES];

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Bench for cic_comb_decimator: four parameterisations driven in turn, checked
// against a difference-equation reference model of the decimated stream.
module tb_cic_comb_decimator;

  localparam int P_N  [4] = '{1, 3, 3, 2};
  localparam int P_R  [4] = '{8, 4, 8, 5};
  localparam int P_M  [4] = '{1, 1, 1, 2};
  localparam int P_IW [4] = '{24, 16, 24, 20};
  localparam int P_OW [4] = '{24, 16, 12, 10};
  localparam int P_SH [4] = '{0, 0, 12, 6};

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] x_s [4];
  logic [3:0]  xv_s, clr_s, yv_s;
  logic [23:0] ya;
  logic [15:0] yb;
  logic [11:0] yc;
  logic [9:0]  yd;

  always #5 clk = ~clk;

  cic_comb_decimator #(.IN_W(24), .OUT_W(24), .N_STAGES(1), .R(8), .M(1), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .x(x_s[0]), .x_valid(xv_s[0]), .phase_clr(clr_s[0]),
    .y(ya), .y_valid(yv_s[0]));
  cic_comb_decimator #(.IN_W(16), .OUT_W(16), .N_STAGES(3), .R(4), .M(1), .SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .x(x_s[1][15:0]), .x_valid(xv_s[1]), .phase_clr(clr_s[1]),
    .y(yb), .y_valid(yv_s[1]));
  cic_comb_decimator dut_c (
    .clk(clk), .rst(rst), .x(x_s[2]), .x_valid(xv_s[2]), .phase_clr(clr_s[2]),
    .y(yc), .y_valid(yv_s[2]));
  cic_comb_decimator #(.IN_W(20), .OUT_W(10), .N_STAGES(2), .R(5), .M(2), .SHIFT(6)) dut_d (
    .clk(clk), .rst(rst), .x(x_s[3][19:0]), .x_valid(xv_s[3]), .phase_clr(clr_s[3]),
    .y(yd), .y_valid(yv_s[3]));

  typedef struct { longint due; logic [63:0] val; } pend_t;
  typedef struct { longint cyc; logic [63:0] val; } obs_t;

  int          sel = 0;
  int          ph;
  longint      cyc = 0;
  logic [63:0] last_y;
  longint      dq[$];
  pend_t       pend[$];
  obs_t        obs[$];
  logic [63:0] cont_y[$];
  int          n_assert = 0;
  int          n_fail = 0;

  function automatic longint binom(input int n, input int k);
    longint b = 1;
    for (int i = 0; i < k; i++) b = b * (n - i) / (i + 1);
    return b;
  endfunction

  // y[k] = sum_j (-1)^j C(N,j) d[k-jM], zero history, modulo 2^IN_W, then sliced.
  function automatic logic [63:0] model_y();
    longint      acc = 0;
    int          k = dq.size() - 1;
    logic [63:0] u;
    for (int j = 0; j <= P_N[sel]; j++) begin
      int idx = k - j * P_M[sel];
      if (idx >= 0) acc += ((j % 2) ? -1 : 1) * binom(P_N[sel], j) * dq[idx];
    end
    u = 64'(acc) & ((64'd1 << P_IW[sel]) - 64'd1);
    return (u >> P_SH[sel]) & ((64'd1 << P_OW[sel]) - 64'd1);
  endfunction

  function automatic logic [63:0] cur_y();
    case (sel)
      0:       return 64'(ya);
      1:       return 64'(yb);
      2:       return 64'(yc);
      default: return 64'(yd);
    endcase
  endfunction

  function automatic logic [63:0] obs_v(input int i);
    return (i < obs.size()) ? obs[i].val : '1;
  endfunction

  function automatic longint obs_c(input int i);
    return (i < obs.size()) ? obs[i].cyc : -1000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s dut=%0d cyc=%0d observed=%0h expected=%0h", tag, sel, cyc, got, exp);
    end
  endtask

  // One clock: advance the model with the inputs presented, then check 1ns after the edge.
  task automatic tick();
    logic exp_v;
    @(posedge clk);
    cyc++;
    if (rst) begin
      ph = 0; dq.delete(); pend.delete(); last_y = '0;
    end else if (clr_s[sel]) begin
      ph = 0; dq.delete(); pend.delete();
    end else if (xv_s[sel]) begin
      if (ph == P_R[sel] - 1) begin
        ph = 0;
        dq.push_back(longint'(x_s[sel]));
        pend.push_back('{cyc + P_N[sel], model_y()});
      end else begin
        ph++;
      end
    end
    #1;
    if (rst) begin
      chk("rst_y", cur_y(), '0);
      chk("rst_y_valid", 64'(yv_s[sel]), '0);
    end else begin
      exp_v = (pend.size() > 0) && (pend[0].due == cyc);
      chk("y_valid", 64'(yv_s[sel]), 64'(exp_v));
      if (exp_v) begin
        last_y = pend[0].val;
        pend.pop_front();
        obs.push_back('{cyc, cur_y()});
      end
      chk("y", cur_y(), last_y);
    end
  endtask

  task automatic drive(input logic v, input logic [23:0] xval, input logic c);
    x_s[sel] = xval; xv_s[sel] = v; clr_s[sel] = c;
    tick();
  endtask

  task automatic select(input int s);
    for (int i = 0; i < 4; i++) begin x_s[i] = '0; xv_s[i] = 1'b0; clr_s[i] = 1'b0; end
    sel = s;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    obs.delete();
  endtask

  initial begin
    logic [15:0] imp [5];
    logic [23:0] xr;
    longint      c8;
    int          n0;

    imp = '{16'd100, 16'hFED4, 16'd300, 16'hFF9C, 16'd0};
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin x_s[i] = '0; xv_s[i] = 1'b0; clr_s[i] = 1'b0; end
    #1;
    chk("por_y_valid", 64'(yv_s), '0);
    chk("por_y", 64'(ya), '0);

    // Ramp +3 per sample, N=1 R=8: steady differences of 24.
    select(0);
    for (int i = 0; i < 48; i++) drive(1'b1, 24'(3 * i), 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("ramp_steady", cur_y(), 64'd24);
    chk("ramp_count", 64'(obs.size()), 64'd6);

    // Same ramp wrapping through zero.
    select(0);
    for (int i = 0; i < 48; i++) drive(1'b1, 24'hFFFFF0 + 24'(3 * i), 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("wrap_steady", cur_y(), 64'd24);
    chk("wrap_mid", obs_v(3), 64'd24);

    // Impulse of 100 on the first decimated sample, N=3 R=4.
    select(1);
    for (int i = 0; i < 28; i++) drive(1'b1, (i == 3) ? 24'd100 : 24'd0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0);
    chk("impulse_count", 64'(obs.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++) chk("impulse_seq", obs_v(i), 64'(imp[i]));

    // Default parameters, constant input every cycle.
    select(2);
    c8 = 0;
    for (int i = 0; i < 48; i++) begin
      drive(1'b1, 24'h123456, 1'b0);
      if (i == 7) c8 = cyc;
    end
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0);
    chk("latency", 64'(obs_c(0) - (c8 - 1)), 64'd4);
    chk("period", 64'(obs_c(1) - obs_c(0)), 64'd8);
    chk("first_out", obs_v(0), 64'h123);
    chk("settled", obs_v(3), 64'd0);
    for (int i = 0; i < obs.size(); i++) cont_y.push_back(obs[i].val);

    // Same input with x_valid every third cycle.
    select(2);
    for (int i = 0; i < 48; i++) begin
      drive(1'b1, 24'h123456, 1'b0);
      drive(1'b0, 24'h0BAD00, 1'b0);
      drive(1'b0, 24'h0BAD00, 1'b0);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0);
    chk("gap_count", 64'(obs.size()), 64'(cont_y.size()));
    chk("gap_period", 64'(obs_c(1) - obs_c(0)), 64'd24);
    for (int i = 0; i < cont_y.size(); i++) chk("gap_values", obs_v(i), cont_y[i]);

    // phase_clr together with a valid sample at phase 5.
    select(2);
    for (int i = 0; i < 13; i++) drive(1'b1, 24'($urandom()), 1'b0);
    drive(1'b1, 24'h7FFFFF, 1'b1);
    n0 = obs.size();
    chk("pre_clr_count", 64'(n0), 64'd1);
    for (int i = 0; i < 7; i++) drive(1'b1, 24'($urandom()), 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b0);
    chk("clr_no_early", 64'(obs.size()), 64'(n0));
    drive(1'b1, 24'h0ABCDE, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0);
    chk("clr_first_out", 64'(obs.size()), 64'(n0 + 1));

    // Reset mid-stream.
    for (int i = 0; i < 5; i++) drive(1'b1, 24'($urandom()), 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_async_y", cur_y(), '0);
    chk("rst_async_y_valid", 64'(yv_s[2]), '0);
    drive(1'b1, 24'h111111, 1'b0);
    drive(1'b1, 24'h222222, 1'b0);
    rst = 1'b0;
    n0 = obs.size();
    for (int i = 0; i < 7; i++) drive(1'b1, 24'($urandom()), 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b0);
    chk("rst_no_early", 64'(obs.size()), 64'(n0));
    drive(1'b1, 24'h0FEDCB, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0);
    chk("rst_first_out", 64'(obs.size()), 64'(n0 + 1));
    chk("rst_first_val", cur_y(), 64'h0FE);

    // Random traffic with gaps and occasional clears, default and M=2 builds.
    for (int s = 2; s < 4; s++) begin
      select(s);
      for (int i = 0; i < 400; i++) begin
        xr = 24'($urandom());
        drive(1'(($urandom() % 10) < 7), xr, 1'(($urandom() % 80) == 0));
      end
      drive(1'b0, '0, 1'b0);
      chk("rand_activity", 64'(obs.size() > 10), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
